// File: rtl/uart_alu_interface.sv
// Command assembler between the UART receiver/transmitter and a combinational ALU.
// Collects operand A, operand B and an opcode byte. It then captures the ALU
// result and hands it to the transmitter as one byte. Only one request is
// processed at a time.
module uart_alu_interface #(
    parameter int NDATA_BITS = 8,
    parameter int NOP_BITS   = 6
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [NDATA_BITS-1:0] i_rx_data,
    input  logic                  i_rx_done,
    input  logic [NDATA_BITS-1:0] i_alu_result,
    input  logic                  i_tx_done,
    output logic [NDATA_BITS-1:0] o_alu_a,
    output logic [NDATA_BITS-1:0] o_alu_b,
    output logic [NOP_BITS-1:0]   o_alu_op,
    output logic [NDATA_BITS-1:0] o_tx_data,
    output logic                  o_tx_start,
    output logic                  o_busy,
    output logic                  o_error
);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    state_t state, state_next;

    logic rx_prev, tx_prev;
    logic byte_evt, tx_evt;
    logic load_a, load_b, load_op, load_res, err_next;

    // Supported ALU opcodes; anything else is rejected with an error pulse.
    function automatic logic op_valid(input logic [NOP_BITS-1:0] op);
        logic ok;
        case (op)
            NOP_BITS'(6'b100000),   // ADD
            NOP_BITS'(6'b100010),   // SUB
            NOP_BITS'(6'b100100),   // AND
            NOP_BITS'(6'b100101),   // OR
            NOP_BITS'(6'b100110),   // XOR
            NOP_BITS'(6'b100111),   // NOR
            NOP_BITS'(6'b000011),   // SRA
            NOP_BITS'(6'b000010):   // SRL
                ok = 1'b1;
            default:
                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // The receiver and transmitter flags are levels, so only their rising edges count as events.
    assign byte_evt = i_rx_done & ~rx_prev;
    assign tx_evt   = i_tx_done & ~tx_prev;

    // Remember last cycle's flag levels for edge detection.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rx_prev <= 1'b0;
            tx_prev <= 1'b0;
        end else begin
            rx_prev <= i_rx_done;
            tx_prev <= i_tx_done;
        end
    end

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= WAIT_A;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and register load strobes; rx events in EXEC/SEND/WAIT_TX are dropped.
    always_comb begin
        state_next = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        load_op    = 1'b0;
        load_res   = 1'b0;
        err_next   = 1'b0;
        case (state)
            WAIT_A: begin
                if (byte_evt) begin
                    load_a     = 1'b1;
                    state_next = WAIT_B;
                end
            end
            WAIT_B: begin
                if (byte_evt) begin
                    load_b     = 1'b1;
                    state_next = WAIT_OP;
                end
            end
            WAIT_OP: begin
                if (byte_evt) begin
                    if (op_valid(i_rx_data[NOP_BITS-1:0])) begin
                        load_op    = 1'b1;
                        state_next = EXEC;
                    end else begin
                        err_next   = 1'b1;
                        state_next = WAIT_A;
                    end
                end
            end
            EXEC: begin
                load_res   = 1'b1;
                state_next = SEND;
            end
            SEND: begin
                state_next = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_evt) begin
                    state_next = WAIT_A;
                end
            end
            default: begin
                state_next = WAIT_A;
            end
        endcase
    end

    // Operand, opcode and result registers plus the registered error pulse.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_alu_a   <= '0;
            o_alu_b   <= '0;
            o_alu_op  <= '0;
            o_tx_data <= '0;
            o_error   <= 1'b0;
        end else begin
            if (load_a) begin
                o_alu_a <= i_rx_data;
            end
            if (load_b) begin
                o_alu_b <= i_rx_data;
            end
            if (load_op) begin
                o_alu_op <= i_rx_data[NOP_BITS-1:0];
            end
            if (load_res) begin
                o_tx_data <= i_alu_result;
            end
            o_error <= err_next;
        end
    end

    // SEND lasts exactly one cycle, so the start strobe is a single-cycle pulse.
    assign o_tx_start = (state == SEND);
    assign o_busy     = (state == EXEC) || (state == SEND) || (state == WAIT_TX);

endmodule

// File: tb/tb_uart_alu_interface.sv
// Self-checking bench for uart_alu_interface: directed scenarios plus randomized
// transactions compared against a transaction-level reference model.
module tb_uart_alu_interface;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] alu_result;
    logic       tx_done;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       error;

    int checks = 0;
    int errors = 0;

    // reference model state
    int         m_cnt;
    bit         m_busy;
    logic [7:0] m_a, m_b;
    logic [5:0] m_op;
    int         m_starts = 0;
    int         m_errs   = 0;

    // observed pulse counts
    int start_cnt = 0;
    int err_cnt   = 0;

    logic [5:0] valid_ops [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                  6'b100110, 6'b100111, 6'b000011, 6'b000010};

    logic [7:0] ra, rb, rop, rx;
    int         sel;

    uart_alu_interface #(.NDATA_BITS(8), .NOP_BITS(6)) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_rx_data    (rx_data),
        .i_rx_done    (rx_done),
        .i_alu_result (alu_result),
        .i_tx_done    (tx_done),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .o_alu_op     (alu_op),
        .o_tx_data    (tx_data),
        .o_tx_start   (tx_start),
        .o_busy       (busy),
        .o_error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: feeds the DUT and also produces the expected result.
    function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        logic signed [7:0] sa;
        sa = a;
        case (op)
            6'b100000: return a + b;
            6'b100010: return a - b;
            6'b100100: return a & b;
            6'b100101: return a | b;
            6'b100110: return a ^ b;
            6'b100111: return ~(a | b);
            6'b000011: return 8'(sa >>> b);
            6'b000010: return a >> b;
            default:   return 8'h00;
        endcase
    endfunction

    assign alu_result = ref_alu(alu_a, alu_b, alu_op);

    function automatic bit op_ok(input logic [5:0] op);
        foreach (valid_ops[i]) if (valid_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Pulse counters sampled on the falling edge.
    always @(negedge clk) begin
        if (tx_start) start_cnt++;
        if (error)    err_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_busy = 1'b0; m_a = '0; m_b = '0; m_op = '0;
    endtask

    // kind: 0 dropped, 1 operand captured, 2 valid opcode, 3 rejected opcode
    task automatic model_byte(input logic [7:0] b, output int kind, output logic [7:0] res);
        res = 8'h00;
        if (m_busy) begin
            kind = 0;
        end else if (m_cnt == 0) begin
            m_a = b; m_cnt = 1; kind = 1;
        end else if (m_cnt == 1) begin
            m_b = b; m_cnt = 2; kind = 1;
        end else begin
            m_cnt = 0;
            if (op_ok(b[5:0])) begin
                m_op = b[5:0]; m_busy = 1'b1; m_starts++; kind = 2;
                res = ref_alu(m_a, m_b, m_op);
            end else begin
                m_errs++; kind = 3;
            end
        end
    endtask

    task automatic check_regs(input string tag);
        check_eq({tag, "_a"},  alu_a,  m_a);
        check_eq({tag, "_b"},  alu_b,  m_b);
        check_eq({tag, "_op"}, alu_op, m_op);
    endtask

    // Present one byte with rx_done held for 'hold' cycles; edge is seen in cycle N.
    task automatic send_byte(input logic [7:0] b, input int hold);
        int kind;
        logic [7:0] res;
        int last;
        @(posedge clk); #1;
        rx_data = b; rx_done = 1'b1;
        model_byte(b, kind, res);
        last = (hold + 1 > 3) ? hold + 1 : 3;
        for (int k = 1; k <= last; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                check_regs("cap");
                check_eq("error_pulse", error, (kind == 3));
                check_eq("busy", busy, m_busy);
            end
            if (k == 2 && kind == 2) begin
                check_eq("tx_start_on", tx_start, 1'b1);
                check_eq("tx_data", tx_data, res);
            end
            if (k == 2 && kind == 3) check_eq("error_off", error, 1'b0);
            if (k == 3 && kind == 2) begin
                check_eq("tx_start_off", tx_start, 1'b0);
                check_eq("busy_wait_tx", busy, 1'b1);
            end
            if (k == last) check_regs("hold");
            if (k == hold) rx_done = 1'b0;
        end
    endtask

    task automatic send_tx(input int hold);
        @(posedge clk); #1;
        tx_done = 1'b1;
        if (m_busy) begin m_busy = 1'b0; m_cnt = 0; end
        for (int k = 1; k <= hold + 1; k++) begin
            @(posedge clk); #1;
            if (k == 1) check_eq("busy_after_tx", busy, m_busy);
            if (k == hold) tx_done = 1'b0;
        end
    endtask

    // rx and tx edges in the same cycle while waiting for tx: tx wins, byte dropped.
    task automatic send_both(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b; rx_done = 1'b1; tx_done = 1'b1;
        m_busy = 1'b0; m_cnt = 0;
        @(posedge clk); #1;
        check_eq("both_busy", busy, 1'b0);
        check_regs("both");
        rx_done = 1'b0; tx_done = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; rx_done = 1'b0; tx_done = 1'b0;
        @(posedge clk); #1;
        model_reset();
        check_regs("rst");
        check_eq("rst_tx_data", tx_data, 8'h00);
        check_eq("rst_tx_start", tx_start, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_error", error, 1'b0);
        rst = 1'b0;
    endtask

    task automatic full_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, input int hold);
        send_byte(a, hold);
        send_byte(b, hold);
        send_byte(op, hold);
    endtask

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_done = 1'b0; tx_done = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_regs("init");
        check_eq("init_tx_data", tx_data, 8'h00);
        check_eq("init_busy", busy, 1'b0);
        check_eq("init_start", tx_start, 1'b0);
        rst = 1'b0;

        // basic ADD: 5 + 3
        full_txn(8'h05, 8'h03, 8'h20, 1);
        check_eq("add_result", tx_data, 8'h08);
        send_tx(2);

        // long held rx_done: one capture per byte
        full_txn(8'h11, 8'h22, 8'h26, 20);
        send_tx(2);

        // invalid opcode, then a valid sequence
        full_txn(8'h7A, 8'h5B, 8'h3F, 2);
        check_eq("inv_busy", busy, 1'b0);
        full_txn(8'h0C, 8'h0A, 8'h24, 2);
        send_tx(1);

        // bytes during WAIT_TX ignored, then OR sequence
        full_txn(8'h40, 8'h02, 8'h22, 1);
        send_byte(8'hAA, 2);
        send_byte(8'hBB, 1);
        send_tx(3);
        full_txn(8'hF0, 8'h0F, 8'h25, 1);
        check_eq("or_a", alu_a, 8'hF0);
        check_eq("or_b", alu_b, 8'h0F);
        send_tx(1);

        // reset after operand B, opcode byte then becomes operand A
        send_byte(8'h33, 1);
        send_byte(8'h44, 1);
        do_reset();
        send_byte(8'h20, 1);
        check_eq("post_rst_a", alu_a, 8'h20);
        do_reset();

        // reset in EXEC aborts the transmit
        send_byte(8'h01, 1);
        send_byte(8'h02, 1);
        @(posedge clk); #1;
        rx_data = 8'h20; rx_done = 1'b1;
        @(posedge clk); #1;
        check_eq("exec_busy", busy, 1'b1);
        rst = 1'b1; rx_done = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check_eq("abort_start", tx_start, 1'b0);
        check_eq("abort_busy", busy, 1'b0);
        check_regs("abort");
        repeat (3) @(posedge clk);
        #1;

        // back-to-back SUB then SRL
        full_txn(8'h09, 8'h04, 8'h22, 1);
        send_tx(1);
        check_eq("b2b_busy_gap", busy, 1'b0);
        full_txn(8'h80, 8'h01, 8'h02, 1);
        send_tx(1);

        // tx_done held high outside WAIT_TX has no effect
        @(posedge clk); #1;
        tx_done = 1'b1;
        full_txn(8'h90, 8'h03, 8'h03, 1);
        @(posedge clk); #1;
        tx_done = 1'b0;
        @(posedge clk); #1;
        check_eq("held_tx_busy", busy, 1'b1);
        send_tx(1);

        // simultaneous rx/tx edges in WAIT_TX
        full_txn(8'h12, 8'h34, 8'h27, 1);
        send_both(8'h99);
        full_txn(8'h56, 8'h78, 8'h20, 1);
        send_tx(1);

        // randomized transactions
        for (int t = 0; t < 40; t++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            sel = $urandom_range(0, 9);
            if (sel < 8) rop = {2'($urandom), valid_ops[sel]};
            else         rop = 8'($urandom);
            send_byte(ra,  $urandom_range(1, 4));
            send_byte(rb,  $urandom_range(1, 4));
            send_byte(rop, $urandom_range(1, 4));
            if (m_busy) begin
                if ($urandom_range(0, 2) == 0) begin
                    rx = 8'($urandom);
                    send_byte(rx, 2);
                end
                if ($urandom_range(0, 3) == 0) begin
                    rx = 8'($urandom);
                    send_both(rx);
                end else begin
                    send_tx($urandom_range(1, 3));
                end
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check_eq("start_count", start_cnt, m_starts);
        check_eq("error_count", err_cnt, m_errs);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
